tx_mac_stream_engine: RTL

Parametrised next-generation transmit engine between the internal circular TX frame buffer and the 10G MAC transmit interface. Frames sit in the buffer as a header qword followed by payload qwords. The block waits until a whole frame is present, streams it to the MAC with the `tx_start`/`tx_ack` handshake, and commits the read pointer back to the host-side logic. It adds back-to-back frames, a programmable inter-frame gap, bad-header drop, wrap markers and statistics.

---
 rtl/tx_mac_stream_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tx_mac_stream_engine.sv
// Streams whole frames from the circular TX buffer to the 10G MAC.
// Handles the MAC handshake, commits the read pointer and keeps statistics.
module tx_mac_stream_engine #(
  parameter int AW         = 10,
  parameter int MAX_BYTES  = 9600,
  parameter int IFG_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [63:0]   tx_data,
  output logic [7:0]    tx_data_valid,
  output logic          tx_start,
  input  logic          tx_ack,
  output logic [AW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  output logic [AW-1:0] commited_rd_address,
  output logic          commited_rd_address_change,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_addr_updated,
  output logic [31:0]   tx_frames,
  output logic [15:0]   tx_drops
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WAIT, S_PREP,
    S_START, S_STREAM, S_IFG
  } state_t;

  state_t        state;
  logic          upd_s1;
  logic          upd_s2;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] wp;
  logic [AW-1:0] ra;
  logic [13:0]   nq;
  logic [13:0]   rem;
  logic [7:0]    lmask;
  logic [63:0]   h1;
  logic [3:0]    icnt;

  logic [AW-1:0] occ;
  logic [15:0]   hlen;
  logic [13:0]   nq_c;
  logic [7:0]    mask_c;
  logic          bad_c;
  logic          room;
  logic [7:0]    next_mask;
  logic [AW-1:0] rp_next;
  logic          commit;

  assign occ  = wp - commited_rd_address;
  assign hlen = rd_data[15:0];
  assign nq_c = 14'((17'(hlen) + 17'd7) >> 3);
  assign mask_c = (hlen[2:0] == 3'd0) ? 8'hFF :
                  8'((9'd1 << hlen[2:0]) - 9'd1);
  // A frame needing more than depth-1 qwords can never be fully present.
  assign bad_c = (hlen == 16'd0) ||
                 (17'(hlen) > 17'(MAX_BYTES)) ||
                 (17'(nq_c) + 17'd1 > 17'((1 << AW) - 1));
  assign room = 17'(occ) >= 17'(nq) + 17'd1;
  assign next_mask = (rem == 14'd1) ? lmask : 8'hFF;
  assign rp_next = commited_rd_address + AW'(nq) + AW'(1);
  assign rd_addr = (state == S_IDLE || state == S_IFG) ?
                   commited_rd_address : ra;
  assign commit = (state == S_START && tx_ack && rem == 14'd0) ||
                  (((state == S_START && tx_ack) ||
                    state == S_STREAM) && rem == 14'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_s1 <= 1'b0;
      upd_s2 <= 1'b0;
      wr_q   <= '0;
      wp     <= '0;
    end else begin
      upd_s1 <= wr_addr_updated;
      upd_s2 <= upd_s1;
      wr_q   <= wr_addr;
      if (upd_s2) wp <= wr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= S_IDLE;
      ra                         <= '0;
      nq                         <= '0;
      rem                        <= '0;
      lmask                      <= '0;
      h1                         <= '0;
      icnt                       <= '0;
      tx_data                    <= '0;
      tx_data_valid              <= '0;
      tx_start                   <= 1'b0;
      commited_rd_address        <= '0;
      commited_rd_address_change <= 1'b0;
      tx_frames                  <= '0;
      tx_drops                   <= '0;
    end else begin
      tx_start                   <= 1'b0;
      commited_rd_address_change <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tx_data       <= '0;
          tx_data_valid <= '0;
          if (occ != '0) state <= S_HDR;
        end
        S_HDR: begin
          if (rd_data[63]) begin
            commited_rd_address        <= '0;
            commited_rd_address_change <= 1'b1;
            state                      <= S_IDLE;
          end else if (bad_c) begin
            commited_rd_address        <= commited_rd_address + AW'(1);
            commited_rd_address_change <= 1'b1;
            if (tx_drops != 16'hFFFF) tx_drops <= tx_drops + 16'd1;
            state                      <= S_IDLE;
          end else begin
            nq    <= nq_c;
            lmask <= mask_c;
            ra    <= commited_rd_address + AW'(1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (room) begin
            ra    <= ra + AW'(1);
            state <= S_PREP;
          end
        end
        S_PREP: begin
          tx_data       <= rd_data;
          tx_data_valid <= (nq == 14'd1) ? lmask : 8'hFF;
          tx_start      <= 1'b1;
          ra            <= ra + AW'(1);
          rem           <= nq - 14'd1;
          state         <= S_START;
        end
        S_START: begin
          // qword1 lands on rd_data only in the first START cycle
          if (tx_start) h1 <= rd_data;
          if (tx_ack) begin
            if (rem == 14'd0) begin
              tx_data       <= '0;
              tx_data_valid <= '0;
            end else begin
              tx_data       <= tx_start ? rd_data : h1;
              tx_data_valid <= next_mask;
              rem           <= rem - 14'd1;
              ra            <= ra + AW'(1);
              state         <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          tx_data       <= rd_data;
          tx_data_valid <= next_mask;
          rem           <= rem - 14'd1;
          ra            <= ra + AW'(1);
        end
        S_IFG: begin
          tx_data       <= '0;
          tx_data_valid <= '0;
          if (tx_data_valid == 8'd0) begin
            if (icnt <= 4'd1)
              state <= (occ != '0) ? S_HDR : S_IDLE;
            else
              icnt <= icnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        commited_rd_address        <= rp_next;
        commited_rd_address_change <= 1'b1;
        tx_frames                  <= tx_frames + 32'd1;
        icnt                       <= 4'(IFG_CYCLES);
        state <= (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
      end
    end
  end

endmodule
